fanout_tree_bcast: RTL and testbench
====================================

Name: fanout_tree_bcast

Overview:
- Parametrised pipelined broadcast tree: replicates one DATA_W-bit word into FANOUT**LEVELS copies through LEVELS register levels; each register drives FANOUT next-level registers.
- Successor to the fixed 16-bit/1024-lane broadcaster. Adds:
  - per-subtree group masking,
  - selectable idle behaviour (hold or zero),
  - in-flight occupancy tracking,
  - delivered-beat counting.
- Sits between a scalar producer (weight/activation fetch) and wide PE arrays.

Parameters:
- DATA_W, 16, width of the broadcast word.
- FANOUT, 4, copies driven by each register; also the number of top-level subtrees (groups). Must be ≥2.
- LEVELS, 5, register levels. Equals latency in cycles. Must be ≥1.
- ZERO_IDLE, 0, 0: registers hold their last value on invalid cycles; 1: registers load zero on invalid cycles.
- CNT_W, 32, width of the delivered-beat counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- data_v  in  1  input word valid.
- in_data  in  DATA_W  word to broadcast.
- grp_mask  in  FANOUT  per-subtree enable, sampled with data_v; bit g enables leaves [g*L/FANOUT, (g+1)*L/FANOUT), where L = FANOUT**LEVELS.
- brdcast_data_v_w  out  1  OR of brdcast_grp_v_w.
- brdcast_grp_v_w  out  FANOUT  per-group output valid.
- brdcast_data_w  out  DATA_W*FANOUT**LEVELS  leaf copies; copy i occupies bits [i*DATA_W +: DATA_W].
- busy  out  1  one or more beats in flight.
- bcast_cnt  out  CNT_W  count of delivered output beats.

Behaviour:
- Reset (synchronous, active-high): every data register, valid bit, occupancy counter and bcast_cnt clear to 0, so all outputs read 0. Reset mid-operation discards all in-flight beats; nothing emerges afterwards.
- Accepted beat: data_v=1 and grp_mask≠0. A beat with data_v=1 and grp_mask=0 is dropped:
  - no output valid,
  - not counted,
  - no register update beyond the idle rule.
- Tree structure:
  - Level 0 holds FANOUT registers; register g copies in_data when the beat is accepted and grp_mask[g]=1.
  - Level k (k=1..LEVELS-1) holds FANOUT**(k+1) registers; register j loads from parent j/FANOUT.
  - Leaves are level LEVELS-1, and leaf i drives copy i.
- Valid tracking:
  - One valid bit per register travels with each data register, so masking stays per subtree.
  - Implementations may share one valid bit per group per level, as all registers of a group see identical valids; observable behaviour must be the same.
- Latency: an accepted beat at cycle t appears on enabled groups at cycle t+LEVELS, valid for exactly 1 cycle.
  - Throughput is one beat per cycle with no backpressure; the consumer must sink every output beat.
  - Back-to-back beats emerge back-to-back, in order, each with its own mask.
- Idle/masked registers:
  - ZERO_IDLE=0: a register whose valid input is 0 keeps its value, so a masked group's leaves hold their previous data.
  - ZERO_IDLE=1: such a register loads 0, so a masked or idle group shows 0 one propagation-step after the gap reaches it.
- Occupancy counter: width $clog2(LEVELS+1); counts accepted beats in flight.
  - +1 on an accepted input beat, −1 when brdcast_data_v_w=1.
  - Both in the same cycle: value unchanged.
  - Never exceeds LEVELS; busy = (count ≠ 0).
- bcast_cnt: increments by 1 on each cycle brdcast_data_v_w=1, regardless of how many groups are enabled. Wraps from 2**CNT_W−1 to 0 with no flag.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Defaults. After reset, apply data_v=1, in_data=16'hA5A5, grp_mask=4'hF for 1 cycle → exactly 5 cycles later brdcast_data_v_w=1 for 1 cycle and all 1024 copies equal 16'hA5A5. busy is high cycles 1-5; bcast_cnt=1.
- Stream 0x0001..0x0008 on 8 consecutive cycles, mask F → outputs emerge as 8 consecutive valid cycles in order. Occupancy peaks at 5; bcast_cnt=8; busy drops the cycle after the last output.
- Send 16'h1111 with mask F, then 16'h2222 with mask 4'b0101 (ZERO_IDLE=0):
  - second output has grp_v=0101 and groups 0 and 2 read 16'h2222;
  - groups 1 and 3 still read 16'h1111.
  - Repeat with ZERO_IDLE=1: groups 1 and 3 read 0.
- data_v=1 with grp_mask=0 → no output valid ever; busy stays 0; bcast_cnt unchanged.
- Assert rst for 1 cycle while 3 beats are in flight → all outputs 0 next cycle, no valids emerge afterwards, busy=0, bcast_cnt=0.
- CNT_W=4: deliver 17 beats → bcast_cnt wraps to 1. Also instantiate DATA_W=8, FANOUT=2, LEVELS=3 → 8 copies at latency 3.

Source files
------------

// File: rtl/fanout_tree_bcast.sv
// Pipelined broadcast tree: one DATA_W word fans out to FANOUT**LEVELS leaf copies over
// LEVELS register stages, with per-subtree masking, occupancy tracking and beat counting.
module fanout_tree_bcast #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FANOUT    = 4,
    parameter int unsigned LEVELS    = 5,
    parameter bit          ZERO_IDLE = 1'b0,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  data_v,
    input  logic [DATA_W-1:0]                     in_data,
    input  logic [FANOUT-1:0]                     grp_mask,
    output logic                                  brdcast_data_v_w,
    output logic [FANOUT-1:0]                     brdcast_grp_v_w,
    output logic [DATA_W*(FANOUT**LEVELS)-1:0]    brdcast_data_w,
    output logic                                  busy,
    output logic [CNT_W-1:0]                      bcast_cnt
);
    localparam int unsigned L     = FANOUT ** LEVELS;
    localparam int unsigned OCC_W = $clog2(LEVELS + 1);

    logic             w_acc;
    logic [OCC_W-1:0] r_occ;
    logic [CNT_W-1:0] r_cnt;

    assign w_acc = data_v && (grp_mask != '0);

    // Valid is tracked per group per level: every register of a group sees the same valid.
    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int unsigned N  = FANOUT ** (k + 1);
        localparam int unsigned GS = FANOUT ** k;

        logic [DATA_W-1:0] r_d   [N];
        logic [FANOUT-1:0] r_v;
        logic [DATA_W-1:0] w_din [N];
        logic [FANOUT-1:0] w_vin;

        if (k == 0) begin : g_root
            always_comb begin
                w_vin = w_acc ? grp_mask : '0;
                for (int unsigned j = 0; j < N; j++) w_din[j] = in_data;
            end
        end else begin : g_node
            always_comb begin
                w_vin = g_lvl[k-1].r_v;
                for (int unsigned j = 0; j < N; j++) w_din[j] = g_lvl[k-1].r_d[j / FANOUT];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_v <= '0;
                for (int unsigned j = 0; j < N; j++) r_d[j] <= '0;
            end else begin
                r_v <= w_vin;
                for (int unsigned j = 0; j < N; j++) begin
                    if (w_vin[j / GS])  r_d[j] <= w_din[j];
                    else if (ZERO_IDLE) r_d[j] <= '0;
                end
            end
        end
    end

    assign brdcast_grp_v_w  = g_lvl[LEVELS-1].r_v;
    assign brdcast_data_v_w = |g_lvl[LEVELS-1].r_v;

    always_comb begin
        brdcast_data_w = '0;
        for (int unsigned i = 0; i < L; i++)
            brdcast_data_w[i*DATA_W +: DATA_W] = g_lvl[LEVELS-1].r_d[i];
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_occ <= '0;
        else if (w_acc && !brdcast_data_v_w)
            r_occ <= r_occ + OCC_W'(1);
        else if (!w_acc && brdcast_data_v_w)
            r_occ <= r_occ - OCC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (brdcast_data_v_w)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign busy      = (r_occ != '0);
    assign bcast_cnt = r_cnt;

endmodule

// File: tb/tb_fanout_tree_bcast.sv
// Scoreboard bench for fanout_tree_bcast: default, zero-idle, 4-bit-counter and small
// (8-bit, fanout 2, 3 levels) instances driven from one directed stimulus stream.
module tb_fanout_tree_bcast;

    typedef struct {
        int unsigned tin;
        int unsigned tout;
        logic [15:0] d;
        logic [3:0]  m;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_v = 1'b0;
    logic [15:0] in_data = '0;
    logic [3:0]  grp_mask = '0;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit run = 1'b0;

    logic           v0, v1, v2, v3;
    logic [3:0]     gv0, gv1, gv2;
    logic [1:0]     gv3;
    logic [16383:0] d0, d1, d2;
    logic [63:0]    d3;
    logic           busy0, busy1, busy2, busy3;
    logic [31:0]    cnt0, cnt1, cnt3;
    logic [3:0]     cnt2;

    fanout_tree_bcast #(.DATA_W(16), .FANOUT(4), .LEVELS(5), .ZERO_IDLE(1'b0), .CNT_W(32)) u_dut0 (
        .clk(clk), .rst(rst), .data_v(data_v), .in_data(in_data), .grp_mask(grp_mask),
        .brdcast_data_v_w(v0), .brdcast_grp_v_w(gv0), .brdcast_data_w(d0),
        .busy(busy0), .bcast_cnt(cnt0));

    fanout_tree_bcast #(.DATA_W(16), .FANOUT(4), .LEVELS(5), .ZERO_IDLE(1'b1), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst(rst), .data_v(data_v), .in_data(in_data), .grp_mask(grp_mask),
        .brdcast_data_v_w(v1), .brdcast_grp_v_w(gv1), .brdcast_data_w(d1),
        .busy(busy1), .bcast_cnt(cnt1));

    fanout_tree_bcast #(.DATA_W(16), .FANOUT(4), .LEVELS(5), .ZERO_IDLE(1'b0), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .data_v(data_v), .in_data(in_data), .grp_mask(grp_mask),
        .brdcast_data_v_w(v2), .brdcast_grp_v_w(gv2), .brdcast_data_w(d2),
        .busy(busy2), .bcast_cnt(cnt2));

    fanout_tree_bcast #(.DATA_W(8), .FANOUT(2), .LEVELS(3), .ZERO_IDLE(1'b0), .CNT_W(32)) u_dut3 (
        .clk(clk), .rst(rst), .data_v(data_v), .in_data(in_data[7:0]), .grp_mask(grp_mask[1:0]),
        .brdcast_data_v_w(v3), .brdcast_grp_v_w(gv3), .brdcast_data_w(d3),
        .busy(busy3), .bcast_cnt(cnt3));

    beat_t       q0[$];
    beat_t       q3[$];
    logic [15:0] hold0 [4];
    logic [15:0] hold3 [4];
    int unsigned exp_cnt0 = 0;
    int unsigned exp_cnt3 = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_leaves(input string nm, input logic [16383:0] act, input int unsigned nleaf,
                              input int unsigned gsz, input int unsigned w, input logic [15:0] eg [4]);
        logic [15:0] a, e, msk;
        int unsigned idx;
        bit          found;
        msk   = (w == 16) ? 16'hFFFF : 16'h00FF;
        idx   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < nleaf; i++) begin
            a = act[i*w +: 16] & msk;
            e = eg[i / gsz] & msk;
            if (a !== e && !found) begin
                found = 1'b1;
                idx   = i;
            end
        end
        chk($sformatf("%s[%0d]", nm, idx), 64'(act[idx*w +: 16] & msk), 64'(eg[idx / gsz] & msk));
    endtask

    always @(negedge clk) begin
        beat_t       b0, b3;
        bit          ev0, ev3;
        int unsigned occ0, occ3;
        logic [15:0] eg0 [4];
        logic [15:0] eg1 [4];
        logic [15:0] eg3 [4];
        if (run) begin
            occ0 = 0;
            occ3 = 0;
            foreach (q0[k]) if (q0[k].tin < cyc) occ0++;
            foreach (q3[k]) if (q3[k].tin < cyc) occ3++;
            chk("busy0", 64'(busy0), 64'(occ0 != 0));
            chk("busy1", 64'(busy1), 64'(occ0 != 0));
            chk("busy2", 64'(busy2), 64'(occ0 != 0));
            chk("busy3", 64'(busy3), 64'(occ3 != 0));
            chk("cnt0", 64'(cnt0), 64'(exp_cnt0));
            chk("cnt1", 64'(cnt1), 64'(exp_cnt0));
            chk("cnt2", 64'(cnt2), 64'(exp_cnt0 % 16));
            chk("cnt3", 64'(cnt3), 64'(exp_cnt3));

            ev0 = 1'b0;
            b0  = '{default: '0};
            if (q0.size() > 0 && q0[0].tout == cyc) begin
                b0  = q0.pop_front();
                ev0 = 1'b1;
            end
            ev3 = 1'b0;
            b3  = '{default: '0};
            if (q3.size() > 0 && q3[0].tout == cyc) begin
                b3  = q3.pop_front();
                ev3 = 1'b1;
            end

            chk("v0", 64'(v0), 64'(ev0));
            chk("v1", 64'(v1), 64'(ev0));
            chk("v2", 64'(v2), 64'(ev0));
            chk("v3", 64'(v3), 64'(ev3));
            chk("grp0", 64'(gv0), 64'(b0.m));
            chk("grp1", 64'(gv1), 64'(b0.m));
            chk("grp2", 64'(gv2), 64'(b0.m));
            chk("grp3", 64'(gv3), 64'(b3.m[1:0]));

            for (int g = 0; g < 4; g++) begin
                if (ev0 && b0.m[g]) hold0[g] = b0.d;
                if (ev3 && b3.m[g]) hold3[g] = b3.d;
                eg0[g] = hold0[g];
                eg1[g] = (ev0 && b0.m[g]) ? b0.d : 16'h0000;
                eg3[g] = hold3[g];
            end
            if (ev0) exp_cnt0++;
            if (ev3) exp_cnt3++;

            chk_leaves("leaf0", d0, 1024, 256, 16, eg0);
            chk_leaves("leaf1", d1, 1024, 256, 16, eg1);
            chk_leaves("leaf2", d2, 1024, 256, 16, eg0);
            chk_leaves("leaf3", 16384'(d3), 8, 4, 8, eg3);

            if (rst) begin
                q0.delete();
                q3.delete();
                for (int g = 0; g < 4; g++) begin
                    hold0[g] = '0;
                    hold3[g] = '0;
                end
                exp_cnt0 = 0;
                exp_cnt3 = 0;
            end
        end
    end

    task automatic beat(input logic v, input logic [15:0] d, input logic [3:0] m);
        @(posedge clk);
        #1;
        data_v   = v;
        in_data  = d;
        grp_mask = m;
        if (v && m != 4'h0)
            q0.push_back(beat_t'{cyc, cyc + 5, d, m});
        if (v && m[1:0] != 2'b00)
            q3.push_back(beat_t'{cyc, cyc + 3, {8'h00, d[7:0]}, {2'b00, m[1:0]}});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 16'h0000, 4'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        data_v = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [3:0] masks [17];

    initial begin
        masks = '{4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'hC, 4'h3, 4'h5, 4'hA,
                  4'h6, 4'h9, 4'hE, 4'h7, 4'hB, 4'hD, 4'hF, 4'h1};
        for (int g = 0; g < 4; g++) begin
            hold0[g] = '0;
            hold3[g] = '0;
        end
        repeat (2) @(posedge clk);
        #1 run = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        beat(1'b1, 16'hA5A5, 4'hF);
        idle(8);

        for (int i = 1; i <= 8; i++) beat(1'b1, 16'(i), 4'hF);
        idle(8);

        beat(1'b1, 16'h1111, 4'hF);
        beat(1'b1, 16'h2222, 4'b0101);
        idle(8);

        beat(1'b1, 16'h3333, 4'h0);
        idle(8);

        beat(1'b1, 16'h4444, 4'hF);
        beat(1'b1, 16'h5555, 4'h3);
        beat(1'b1, 16'h6666, 4'hF);
        do_reset();
        idle(8);

        for (int i = 0; i < 17; i++) beat(1'b1, 16'h1000 + 16'(i * 16'h0111), masks[i]);
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
